// File: rtl/gb_sched_pkg.sv
// Shared encodings and defaults for the global-buffer bank scheduler.
// The bank encoding mirrors the per-bank SRAM_CTRL so both sides agree on it.
package gb_sched_pkg;

    localparam int DEF_NUM_BANK   = 16;
    localparam int DEF_ADDR_WIDTH = 9;
    localparam int DEF_SRAM_DEPTH = 512;
    localparam int DEF_ID_WIDTH   = 6;

    typedef enum logic [1:0] {
        WR_IDLE      = 2'b00,
        WR_REQ_READY = 2'b01,
        WR_WRITE     = 2'b11
    } wr_state_e;

    typedef enum logic [1:0] {
        RD_IDLE       = 2'b00,
        RD_READ_READY = 2'b01,
        RD_READ       = 2'b11
    } rd_state_e;

    typedef enum logic [1:0] {
        BANK_EMPTY         = 2'b00,
        BANK_WRITE         = 2'b01,
        BANK_READY_TO_READ = 2'b10,
        BANK_READ          = 2'b11
    } bank_state_e;

    // Zero means one word; anything beyond the bank depth is clamped so the
    // address counters can never run past the last word.
    function automatic logic [9:0] clamp_words(input logic [9:0] cfg, input int depth);
        if (cfg == 10'd0) begin
            return 10'd1;
        end
        if (int'(cfg) > depth) begin
            return 10'(depth);
        end
        return cfg;
    endfunction

endpackage

// File: rtl/gb_bank_order_fifo.sv
// Small FIFO remembering the order in which banks were filled.
// Head is read combinationally so the read FSM can act on it the cycle after a push.
module gb_bank_order_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/gb_bank_scheduler.sv
// Global-buffer master for the per-bank SRAM handshake: round-robin write fills,
// in-order multi-pass reads, shared strobes/addresses and done/cover pulses.
module gb_bank_scheduler
    import gb_sched_pkg::*;
#(
    parameter int NUM_BANK   = DEF_NUM_BANK,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int SRAM_DEPTH = DEF_SRAM_DEPTH,
    parameter int ID_WIDTH   = DEF_ID_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [9:0]            cfg_wr_words,
    input  logic [9:0]            cfg_rd_words,
    input  logic [3:0]            cfg_rd_pass,
    input  logic [NUM_BANK-1:0]   Wr_Req,
    input  logic [NUM_BANK-1:0]   Rd_Prepare,
    input  logic                  IFSRAM_Conf_rdy,
    input  logic                  PESRAM_rdy,
    input  logic                  if_valid,
    input  logic                  pe_rd_rdy,
    output logic [1:0]            State_Wr,
    output logic [1:0]            State_Rd,
    output logic [ID_WIDTH-1:0]   SRAMIF_Wr_ID,
    output logic [ID_WIDTH-1:0]   SRAMIF_Rd_ID,
    output logic                  write_en,
    output logic [ADDR_WIDTH-1:0] addr_w,
    output logic                  read_en,
    output logic [ADDR_WIDTH-1:0] addr_r,
    output logic                  rd_data_valid,
    output logic                  write_SRAM_done,
    output logic                  read_SRAM_done,
    output logic                  SRAM_Cover_Flag
);

    localparam int IDX_W = $clog2(NUM_BANK);

    wr_state_e             wr_state_reg;
    rd_state_e             rd_state_reg;
    logic [IDX_W-1:0]      wr_bank_reg;
    logic [IDX_W-1:0]      rr_ptr_reg;
    logic [IDX_W-1:0]      grant_idx;
    logic [IDX_W-1:0]      cand;
    logic                  grant_found;
    logic [ID_WIDTH-1:0]   rd_id_reg;
    logic [ID_WIDTH-1:0]   fifo_head;
    logic [ADDR_WIDTH-1:0] wcnt_reg;
    logic [ADDR_WIDTH-1:0] rcnt_reg;
    logic [ADDR_WIDTH-1:0] wr_last_reg;
    logic [ADDR_WIDTH-1:0] rd_last_reg;
    logic [3:0]            pass_reg;
    logic [3:0]            pass_last_reg;
    logic                  write_done_reg;
    logic                  read_done_reg;
    logic                  cover_reg;
    logic                  rd_valid_reg;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  wr_beat;
    logic                  rd_beat;
    logic                  wr_last_beat;
    logic                  rd_last_beat;
    logic                  last_pass;
    logic                  head_prepared;

    assign wr_beat      = (wr_state_reg == WR_WRITE) && if_valid;
    assign rd_beat      = (rd_state_reg == RD_READ) && pe_rd_rdy;
    assign wr_last_beat = wr_beat && (wcnt_reg == wr_last_reg);
    assign rd_last_beat = rd_beat && (rcnt_reg == rd_last_reg);
    assign last_pass    = (pass_reg == pass_last_reg);

    // First requesting bank at or after rr_ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NUM_BANK; i++) begin
            cand = IDX_W'((int'(rr_ptr_reg) + i) % NUM_BANK);
            if (!grant_found && Wr_Req[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        head_prepared = 1'b0;
        for (int i = 0; i < NUM_BANK; i++) begin
            if (fifo_head == ID_WIDTH'(i)) begin
                head_prepared = Rd_Prepare[i];
            end
        end
    end

    gb_bank_order_fifo #(
        .WIDTH (ID_WIDTH),
        .DEPTH (NUM_BANK)
    ) u_order_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start),
        .push      (wr_last_beat),
        .push_data (SRAMIF_Wr_ID),
        .pop       (rd_last_beat && last_pass),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_last_reg   <= '0;
            rd_last_reg   <= '0;
            pass_last_reg <= '0;
        end else if (start) begin
            wr_last_reg   <= ADDR_WIDTH'(clamp_words(cfg_wr_words, SRAM_DEPTH) - 10'd1);
            rd_last_reg   <= ADDR_WIDTH'(clamp_words(cfg_rd_words, SRAM_DEPTH) - 10'd1);
            pass_last_reg <= (cfg_rd_pass == 4'd0) ? 4'd0 : cfg_rd_pass - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_reg   <= WR_IDLE;
            wr_bank_reg    <= '0;
            rr_ptr_reg     <= '0;
            wcnt_reg       <= '0;
            write_done_reg <= 1'b0;
        end else if (start) begin
            wr_state_reg   <= WR_IDLE;
            wr_bank_reg    <= '0;
            rr_ptr_reg     <= '0;
            wcnt_reg       <= '0;
            write_done_reg <= 1'b0;
        end else begin
            write_done_reg <= 1'b0;
            case (wr_state_reg)
                WR_IDLE: begin
                    if (grant_found && !fifo_full) begin
                        wr_bank_reg  <= grant_idx;
                        wr_state_reg <= WR_REQ_READY;
                    end
                end
                WR_REQ_READY: begin
                    if (IFSRAM_Conf_rdy) begin
                        wr_state_reg <= WR_WRITE;
                    end
                end
                WR_WRITE: begin
                    if (wr_last_beat) begin
                        wcnt_reg       <= '0;
                        write_done_reg <= 1'b1;
                        rr_ptr_reg     <= (wr_bank_reg == IDX_W'(NUM_BANK - 1)) ?
                                          '0 : wr_bank_reg + IDX_W'(1);
                        wr_state_reg   <= WR_IDLE;
                    end else if (wr_beat) begin
                        wcnt_reg <= wcnt_reg + ADDR_WIDTH'(1);
                    end
                end
                default: wr_state_reg <= WR_IDLE;
            endcase
        end
    end

    // A non-final pass leaves the bank at the FIFO head, so RD_IDLE simply re-arms on it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_reg  <= RD_IDLE;
            rd_id_reg     <= '0;
            rcnt_reg      <= '0;
            pass_reg      <= '0;
            read_done_reg <= 1'b0;
            cover_reg     <= 1'b0;
            rd_valid_reg  <= 1'b0;
        end else if (start) begin
            rd_state_reg  <= RD_IDLE;
            rd_id_reg     <= '0;
            rcnt_reg      <= '0;
            pass_reg      <= '0;
            read_done_reg <= 1'b0;
            cover_reg     <= 1'b0;
            rd_valid_reg  <= 1'b0;
        end else begin
            read_done_reg <= 1'b0;
            cover_reg     <= 1'b0;
            rd_valid_reg  <= rd_beat;
            case (rd_state_reg)
                RD_IDLE: begin
                    if (!fifo_empty && head_prepared) begin
                        rd_id_reg    <= fifo_head;
                        rd_state_reg <= RD_READ_READY;
                    end
                end
                RD_READ_READY: begin
                    if (PESRAM_rdy) begin
                        rd_state_reg <= RD_READ;
                    end
                end
                RD_READ: begin
                    if (rd_last_beat) begin
                        rcnt_reg      <= '0;
                        read_done_reg <= 1'b1;
                        cover_reg     <= last_pass;
                        pass_reg      <= last_pass ? 4'd0 : pass_reg + 4'd1;
                        rd_state_reg  <= RD_IDLE;
                    end else if (rd_beat) begin
                        rcnt_reg <= rcnt_reg + ADDR_WIDTH'(1);
                    end
                end
                default: rd_state_reg <= RD_IDLE;
            endcase
        end
    end

    assign State_Wr        = wr_state_reg;
    assign State_Rd        = rd_state_reg;
    assign SRAMIF_Wr_ID    = ID_WIDTH'(wr_bank_reg);
    assign SRAMIF_Rd_ID    = rd_id_reg;
    assign write_en        = wr_beat;
    assign addr_w          = wcnt_reg;
    assign read_en         = rd_beat;
    assign addr_r          = rcnt_reg;
    assign rd_data_valid   = rd_valid_reg;
    assign write_SRAM_done = write_done_reg;
    assign read_SRAM_done  = read_done_reg;
    assign SRAM_Cover_Flag = cover_reg;

endmodule

// File: tb/tb_gb_bank_scheduler.sv
// Directed bench for gb_bank_scheduler: a vector table for the first fill, then
// hand-written sequences for round robin, multi-pass reads, stalls, flush and reset.
module tb_gb_bank_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  cfg_wr_words;
    logic [9:0]  cfg_rd_words;
    logic [3:0]  cfg_rd_pass;
    logic [15:0] Wr_Req;
    logic [15:0] Rd_Prepare;
    logic        IFSRAM_Conf_rdy;
    logic        PESRAM_rdy;
    logic        if_valid;
    logic        pe_rd_rdy;
    logic [1:0]  State_Wr;
    logic [1:0]  State_Rd;
    logic [5:0]  SRAMIF_Wr_ID;
    logic [5:0]  SRAMIF_Rd_ID;
    logic        write_en;
    logic [8:0]  addr_w;
    logic        read_en;
    logic [8:0]  addr_r;
    logic        rd_data_valid;
    logic        write_SRAM_done;
    logic        read_SRAM_done;
    logic        SRAM_Cover_Flag;

    int passed = 0;
    int total  = 0;
    int n;

    typedef struct {
        logic [15:0] wr_req;
        logic        conf;
        logic        valid;
        logic [1:0]  st;
        logic        we;
        logic [8:0]  aw;
        logic        done;
        logic [5:0]  id;
    } vec_t;

    vec_t vecs [9];

    gb_bank_scheduler dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .cfg_wr_words    (cfg_wr_words),
        .cfg_rd_words    (cfg_rd_words),
        .cfg_rd_pass     (cfg_rd_pass),
        .Wr_Req          (Wr_Req),
        .Rd_Prepare      (Rd_Prepare),
        .IFSRAM_Conf_rdy (IFSRAM_Conf_rdy),
        .PESRAM_rdy      (PESRAM_rdy),
        .if_valid        (if_valid),
        .pe_rd_rdy       (pe_rd_rdy),
        .State_Wr        (State_Wr),
        .State_Rd        (State_Rd),
        .SRAMIF_Wr_ID    (SRAMIF_Wr_ID),
        .SRAMIF_Rd_ID    (SRAMIF_Rd_ID),
        .write_en        (write_en),
        .addr_w          (addr_w),
        .read_en         (read_en),
        .addr_r          (addr_r),
        .rd_data_valid   (rd_data_valid),
        .write_SRAM_done (write_SRAM_done),
        .read_SRAM_done  (read_SRAM_done),
        .SRAM_Cover_Flag (SRAM_Cover_Flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Fill one bank with if_valid held high; the bank stops requesting once full.
    task automatic do_fill(input int exp_id);
        int k;
        k = 0;
        while (State_Wr != 2'b01 && k < 40) begin
            tick();
            k++;
        end
        chk("fill_grant_seen", 32'(k < 40), 1);
        chk("fill_wr_id", SRAMIF_Wr_ID, exp_id);
        if_valid = 1'b1;
        tick();
        for (int b = 0; b < 4; b++) begin
            chk("fill_write_en", write_en, 1);
            chk("fill_addr_w", addr_w, b);
            tick();
        end
        chk("fill_done", write_SRAM_done, 1);
        chk("fill_state_idle", State_Wr, 2'b00);
        if_valid = 1'b0;
        Wr_Req   = Wr_Req & ~(16'h0001 << exp_id);
        $display("fill   bank %0d complete at %0t", exp_id, $time);
    endtask

    // One 3-word read pass; optionally stalls pe_rd_rdy for 5 cycles after beat 0.
    task automatic read_pass(input int exp_id, input logic exp_cover, input logic pause);
        int k;
        k = 0;
        while (State_Rd != 2'b11 && k < 40) begin
            tick();
            k++;
        end
        chk("rd_start_seen", 32'(k < 40), 1);
        chk("rd_id", SRAMIF_Rd_ID, exp_id);
        chk("rd_beat0_en", read_en, 1);
        chk("rd_beat0_addr", addr_r, 0);
        chk("rd_beat0_valid", rd_data_valid, 0);
        if (pause) begin
            tick();
            pe_rd_rdy = 1'b0;
            #1;
            chk("stall_en", read_en, 0);
            chk("stall_addr", addr_r, 1);
            chk("stall_valid_tail", rd_data_valid, 1);
            for (int p = 1; p < 5; p++) begin
                tick();
                chk("stall_en", read_en, 0);
                chk("stall_addr", addr_r, 1);
                chk("stall_valid", rd_data_valid, 0);
            end
            tick();
            pe_rd_rdy = 1'b1;
            #1;
            chk("resume_en", read_en, 1);
            chk("resume_addr", addr_r, 1);
            chk("resume_valid", rd_data_valid, 0);
        end else begin
            tick();
            chk("rd_beat1_en", read_en, 1);
            chk("rd_beat1_addr", addr_r, 1);
            chk("rd_beat1_valid", rd_data_valid, 1);
        end
        tick();
        chk("rd_beat2_en", read_en, 1);
        chk("rd_beat2_addr", addr_r, 2);
        chk("rd_beat2_valid", rd_data_valid, 1);
        tick();
        chk("rd_done", read_SRAM_done, 1);
        chk("rd_cover", SRAM_Cover_Flag, 32'(exp_cover));
        chk("rd_state_idle", State_Rd, 2'b00);
        chk("rd_done_en", read_en, 0);
        chk("rd_done_valid", rd_data_valid, 1);
        $display("read   bank %0d pass done cover=%0d at %0t", exp_id, exp_cover, $time);
    endtask

    initial begin
        rst_n           = 1'b1;
        start           = 1'b0;
        cfg_wr_words    = 10'd4;
        cfg_rd_words    = 10'd3;
        cfg_rd_pass     = 4'd2;
        Wr_Req          = '0;
        Rd_Prepare      = '0;
        IFSRAM_Conf_rdy = 1'b1;
        PESRAM_rdy      = 1'b1;
        if_valid        = 1'b0;
        pe_rd_rdy       = 1'b1;

        //            wr_req     conf  valid  st     we    aw    done  id
        vecs[0] = '{16'h0001, 1'b1, 1'b0, 2'b00, 1'b0, 9'd0, 1'b0, 6'd0};
        vecs[1] = '{16'h0001, 1'b1, 1'b0, 2'b01, 1'b0, 9'd0, 1'b0, 6'd0};
        vecs[2] = '{16'h0001, 1'b1, 1'b1, 2'b11, 1'b1, 9'd0, 1'b0, 6'd0};
        vecs[3] = '{16'h0001, 1'b1, 1'b1, 2'b11, 1'b1, 9'd1, 1'b0, 6'd0};
        vecs[4] = '{16'h0001, 1'b1, 1'b0, 2'b11, 1'b0, 9'd2, 1'b0, 6'd0};
        vecs[5] = '{16'h0001, 1'b1, 1'b1, 2'b11, 1'b1, 9'd2, 1'b0, 6'd0};
        vecs[6] = '{16'h0001, 1'b1, 1'b1, 2'b11, 1'b1, 9'd3, 1'b0, 6'd0};
        vecs[7] = '{16'h0000, 1'b1, 1'b0, 2'b00, 1'b0, 9'd0, 1'b1, 6'd0};
        vecs[8] = '{16'h0000, 1'b1, 1'b0, 2'b00, 1'b0, 9'd0, 1'b0, 6'd0};

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_state_wr", State_Wr, 0);
        chk("rst_state_rd", State_Rd, 0);
        chk("rst_wr_id", SRAMIF_Wr_ID, 0);
        chk("rst_rd_id", SRAMIF_Rd_ID, 0);
        chk("rst_write_en", write_en, 0);
        chk("rst_read_en", read_en, 0);
        chk("rst_valid", rd_data_valid, 0);
        chk("rst_wdone", write_SRAM_done, 0);
        chk("rst_rdone", read_SRAM_done, 0);
        chk("rst_cover", SRAM_Cover_Flag, 0);
        rst_n = 1'b1;
        pulse_start();

        for (int k = 0; k < 9; k++) begin
            tick();
            Wr_Req          = vecs[k].wr_req;
            IFSRAM_Conf_rdy = vecs[k].conf;
            if_valid        = vecs[k].valid;
            #1;
            chk($sformatf("vec%0d_state_wr", k), State_Wr, vecs[k].st);
            chk($sformatf("vec%0d_write_en", k), write_en, vecs[k].we);
            chk($sformatf("vec%0d_addr_w", k), addr_w, vecs[k].aw);
            chk($sformatf("vec%0d_wdone", k), write_SRAM_done, vecs[k].done);
            chk($sformatf("vec%0d_wr_id", k), SRAMIF_Wr_ID, vecs[k].id);
            $display("vector %0d applied at %0t", k, $time);
        end

        // Bank 0 read twice, then released.
        Rd_Prepare = 16'h0001;
        read_pass(0, 1'b0, 1'b0);
        read_pass(0, 1'b1, 1'b0);
        Rd_Prepare = 16'hFFFF;
        repeat (4) tick();
        chk("fifo_empty_after_cover", State_Rd, 2'b00);
        Rd_Prepare = 16'h0000;

        // rr_ptr is 1 after bank 0: bank 15 wins, then wrap to bank 0.
        Wr_Req = 16'h8001;
        do_fill(15);
        do_fill(0);

        pulse_start();
        Rd_Prepare = 16'hFFFF;
        repeat (3) tick();
        chk("start_flushes_fifo", State_Rd, 2'b00);
        Rd_Prepare = 16'h0000;

        // Fill order 3 then 7 must be the read order.
        Wr_Req = 16'h0088;
        do_fill(3);
        do_fill(7);
        Rd_Prepare = 16'h0088;
        read_pass(3, 1'b0, 1'b1);
        read_pass(3, 1'b1, 1'b0);
        read_pass(7, 1'b0, 1'b0);
        read_pass(7, 1'b1, 1'b0);
        Rd_Prepare = 16'h0000;

        // start in the middle of a fill, with bank 5 already queued.
        Wr_Req = 16'h0020;
        do_fill(5);
        Wr_Req   = 16'h0001;
        if_valid = 1'b1;
        n = 0;
        while (State_Wr != 2'b11 && n < 40) begin
            tick();
            n++;
        end
        chk("flush_fill_started", 32'(n < 40), 1);
        tick();
        tick();
        chk("flush_addr_before", addr_w, 2);
        start  = 1'b1;
        Wr_Req = 16'h0000;
        tick();
        start = 1'b0;
        #1;
        chk("flush_state_wr", State_Wr, 2'b00);
        chk("flush_state_rd", State_Rd, 2'b00);
        chk("flush_write_en", write_en, 0);
        chk("flush_no_done", write_SRAM_done, 0);
        chk("flush_addr_w", addr_w, 0);
        tick();
        chk("flush_no_late_done", write_SRAM_done, 0);
        if_valid   = 1'b0;
        Rd_Prepare = 16'hFFFF;
        repeat (3) tick();
        chk("flush_fifo_empty", State_Rd, 2'b00);
        Rd_Prepare = 16'h0000;
        $display("flush  start mid-fill checked at %0t", $time);

        // Asynchronous reset in the middle of a read pass.
        Wr_Req = 16'h0004;
        do_fill(2);
        Rd_Prepare = 16'h0004;
        n = 0;
        while (State_Rd != 2'b11 && n < 40) begin
            tick();
            n++;
        end
        chk("arst_read_started", 32'(n < 40), 1);
        tick();
        chk("arst_pre_addr", addr_r, 1);
        chk("arst_pre_rd_id", SRAMIF_Rd_ID, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state_rd", State_Rd, 2'b00);
        chk("arst_read_en", read_en, 0);
        chk("arst_addr_r", addr_r, 0);
        chk("arst_valid", rd_data_valid, 0);
        chk("arst_rd_id", SRAMIF_Rd_ID, 0);
        chk("arst_state_wr", State_Wr, 2'b00);
        $display("reset  async reset mid-read checked at %0t", $time);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/gb_bank_scheduler.md
Name: gb_bank_scheduler

Overview:
- Global-buffer side master that drives the per-bank SRAM_CTRL handshake for all NUM_BANK banks.
- Monitors each bank's Wr_Req and Rd_Prepare, then runs the write FSM (State_Wr, SRAMIF_Wr_ID) and the read FSM (State_Rd, SRAMIF_Rd_ID).
- Generates shared write_en/read_en/addr and the write_SRAM_done/read_SRAM_done/SRAM_Cover_Flag pulses.
- Banks are read in the order they were filled, each reused cfg_rd_pass times before being released.

Parameters:
- NUM_BANK, 16, number of banks; bank index = SRAM_ID.
- ADDR_WIDTH, 9, SRAM word address width.
- SRAM_DEPTH, 512, words per bank.
- ID_WIDTH, 6, width of bank-ID buses (upper bits driven 0).

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- start  in  1  sync flush plus config capture (same signal fed to banks)
- cfg_wr_words  in  10  words per bank fill (1..512; 0 treated as 1)
- cfg_rd_words  in  10  words per read pass (1..512; 0 treated as 1)
- cfg_rd_pass  in  4  read passes per fill (0 treated as 1)
- Wr_Req  in  NUM_BANK  per-bank "empty" flags
- Rd_Prepare  in  NUM_BANK  per-bank "ready to read" flags
- IFSRAM_Conf_rdy  in  1  input interface confirms write grant
- PESRAM_rdy  in  1  PE side confirms read grant
- if_valid  in  1  write beat valid (data path external)
- pe_rd_rdy  in  1  PE accepts a read beat this cycle
- State_Wr  out  2  WR_IDLE=00, WR_REQ_READY=01, WR_WRITE=11
- State_Rd  out  2  RD_IDLE=00, RD_READ_READY=01, RD_READ=11
- SRAMIF_Wr_ID  out  ID_WIDTH  bank being written
- SRAMIF_Rd_ID  out  ID_WIDTH  bank being read (integrator fans it out to all four Rd_ID inputs)
- write_en  out  1  SRAM write strobe
- addr_w  out  ADDR_WIDTH  write address
- read_en  out  1  SRAM read strobe
- addr_r  out  ADDR_WIDTH  read address
- rd_data_valid  out  1  read_en delayed 1 cycle (SRAM read latency)
- write_SRAM_done  out  1  1-cycle pulse, fill complete
- read_SRAM_done  out  1  1-cycle pulse, pass complete
- SRAM_Cover_Flag  out  1  high with read_SRAM_done when that pass is the last

Behaviour:
- Reset (async) and start (sync, highest priority): both FSMs IDLE; IDs 0; counters 0; write_en, read_en, rd_data_valid, dones and Cover 0; order FIFO cleared; rr_ptr 0. On start, capture cfg_* into registers; cfg inputs are ignored at other times.
- Write FSM:
  - WR_IDLE: if any Wr_Req bit is set and the FIFO is not full, grant the first set bit searching from rr_ptr (round robin). Next cycle: SRAMIF_Wr_ID = grant, State_Wr = WR_REQ_READY.
  - WR_REQ_READY: hold the ID until IFSRAM_Conf_rdy=1, then go to WR_WRITE on the next edge. Bank transitions EMPTY->WRITE on the same edge.
  - WR_WRITE: in each cycle with if_valid=1, write_en=1 (combinational from if_valid and state), addr_w = wcnt, wcnt++. On the beat where wcnt == words-1: next cycle write_SRAM_done=1, push ID to FIFO, rr_ptr = ID+1 mod NUM_BANK, wcnt=0, return to WR_IDLE.
  - Min fill overhead: 2 cycles from grant to first beat.
- Read FSM:
  - RD_IDLE: if the FIFO is non-empty and Rd_Prepare[head]=1, set SRAMIF_Rd_ID = head and State_Rd = RD_READ_READY next cycle.
  - RD_READ_READY: wait for PESRAM_rdy=1, then go to RD_READ.
  - RD_READ: in each cycle with pe_rd_rdy=1, read_en=1, addr_r = rcnt, rcnt++. On the last beat: next cycle read_SRAM_done=1 and SRAM_Cover_Flag = (pass == passes-1).
    - If Cover: pop FIFO and set pass=0.
    - Else: pass++ and the same bank stays at the head.
    - Either way return to RD_IDLE.
- Simultaneous FIFO push and pop in one cycle: both take effect, count unchanged. Push to an empty FIFO is visible to the read FSM the following cycle.
- Full/empty: FIFO depth NUM_BANK, so it never overflows in normal use; the write grant is still gated on !full. An empty FIFO holds read in RD_IDLE.
- A Wr_Req or Rd_Prepare dropping while waiting in *_READY is not checked (the bank FSM guarantees it holds).
- Counters wrap only via the last-beat compare; addr never exceeds words-1.

Decomposition:
- Package gb_sched_pkg:
  - state encodings: WR_*, RD_*, and bank EMPTY/WRITE/READY_TO_READ/READ;
  - NUM_BANK, ADDR_WIDTH, ID_WIDTH defaults.
- Sub-module gb_bank_order_fifo: ID_WIDTH x NUM_BANK synchronous FIFO with push, pop, head, empty, full, and a sync clear on start.

Test Plan:
- After reset with cfg_wr_words=4, Wr_Req=16'h0001 and IFSRAM_Conf_rdy=1:
  - State_Wr goes 00->01->11;
  - with if_valid held, 4 beats on addr_w 0..3;
  - write_SRAM_done pulses once; State_Wr returns to 00.
- Round robin: Wr_Req=16'h8001 held, rr_ptr=1 -> grant bank 15; after that fill, grant bank 0.
- cfg_rd_pass=2, cfg_rd_words=3, bank 0 in FIFO, Rd_Prepare[0]=1, PESRAM_rdy=1:
  - two passes of addr_r 0..2;
  - first read_SRAM_done has Cover=0, second has Cover=1;
  - FIFO then empty.
- Read ordering: fill banks 3 then 7 -> SRAMIF_Rd_ID is 3 for all passes, then 7.
- pe_rd_rdy=0 mid-pass for 5 cycles: read_en=0, addr_r held; resumes at the next address; rd_data_valid always equals read_en delayed by 1.
- start asserted during WR_WRITE at wcnt=2: next cycle both FSMs are IDLE, write_en=0, FIFO empty, no done pulse.
- Async rst_n low mid-read: all outputs immediately at reset values.
